psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_pkg.sv | 27 ++
 rtl/sat_add16.sv | 22 ++
 rtl/psum_accumulator.sv | 191 +++++++++++++++++++
 tb/tb_psum_accumulator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: widths, FSM states,
// saturation limits and the output ReLU helper.
package psum_accumulator_pkg;

  localparam int unsigned PSUM_DATA_WIDTH = 16;
  // 416*416 pixels fit in 18 bits.
  localparam int unsigned PSUM_ADDR_WIDTH = 18;

  localparam logic signed [PSUM_DATA_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [PSUM_DATA_WIDTH-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StDone
  } acc_state_e;

  // Clamp negative values to zero when ReLU is enabled.
  function automatic logic signed [PSUM_DATA_WIDTH-1:0] relu_clip(
    input logic signed [PSUM_DATA_WIDTH-1:0] v,
    input logic                              en
  );
    return (en && v[PSUM_DATA_WIDTH-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/sat_add16.sv
// 16-bit signed saturating adder, purely combinational.
module sat_add16
  import psum_accumulator_pkg::*;
(
  input  logic signed [PSUM_DATA_WIDTH-1:0] i_a,
  input  logic signed [PSUM_DATA_WIDTH-1:0] i_b,
  output logic signed [PSUM_DATA_WIDTH-1:0] o_sum
);

  logic [PSUM_DATA_WIDTH:0] w_wide;

  assign w_wide = {i_a[PSUM_DATA_WIDTH-1], i_a} + {i_b[PSUM_DATA_WIDTH-1], i_b};

  // Overflow when the two top bits of the sign-extended sum disagree.
  always_comb begin
    o_sum = w_wide[PSUM_DATA_WIDTH-1:0];
    if (w_wide[PSUM_DATA_WIDTH] != w_wide[PSUM_DATA_WIDTH-1]) begin
      o_sum = w_wide[PSUM_DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-channel partial sums of one output channel into the psum
// buffer and streams the final (optionally ReLU'd) pixels out.
// Pipeline: valid cycle t issues the buffer read, t+1 adds, t+2 writes/outputs.
module psum_accumulator #(
  parameter int unsigned DATA_WIDTH = psum_accumulator_pkg::PSUM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = psum_accumulator_pkg::PSUM_ADDR_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [8:0]                   i_max_width,
  input  logic [8:0]                   i_max_height,
  input  logic [9:0]                   i_max_ci,
  input  logic                         i_relu_en,
  input  logic signed [DATA_WIDTH-1:0] i_psum_data,
  input  logic                         i_psum_valid,
  input  logic                         i_psum_done,
  output logic                         o_mem_ren,
  output logic [ADDR_WIDTH-1:0]        o_mem_raddr,
  input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
  output logic                         o_mem_wen,
  output logic [ADDR_WIDTH-1:0]        o_mem_waddr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_done,
  output logic                         o_busy,
  output logic                         o_err
);
  import psum_accumulator_pkg::*;

  // Job configuration and counters
  acc_state_e             r_state;
  logic [8:0]             r_w;
  logic [8:0]             r_h;
  logic [9:0]             r_ci;
  logic                   r_relu;
  logic [ADDR_WIDTH-1:0]  r_p;
  logic [9:0]             r_ch;
  logic                   r_drain;

  // Stage 1 (cycle t+1)
  logic                   r_s1_valid;
  logic                   r_s1_rd;
  logic                   r_s1_final;
  logic [ADDR_WIDTH-1:0]  r_s1_addr;
  logic signed [DATA_WIDTH-1:0] r_s1_psum;

  // Registered outputs (cycle t+2)
  logic                   r_valid;
  logic signed [DATA_WIDTH-1:0] r_data;
  logic                   r_wen;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_err;

  logic [ADDR_WIDTH-1:0]  w_total;
  logic                   w_in_range;
  logic                   w_accept;
  logic                   w_overflow;
  logic                   w_rd;
  logic                   w_final;
  logic [ADDR_WIDTH-1:0]  w_count_next;
  logic signed [DATA_WIDTH-1:0] w_add;
  logic signed [DATA_WIDTH-1:0] w_sum;

  assign w_total      = ADDR_WIDTH'(r_w) * ADDR_WIDTH'(r_h);
  assign w_in_range   = (r_p < w_total);
  assign w_accept     = (r_state == StAccum) && i_psum_valid && w_in_range;
  assign w_overflow   = (r_state == StAccum) && i_psum_valid && !w_in_range;
  assign w_rd         = w_accept && (r_ch != 10'd0);
  assign w_final      = (r_ch == r_ci);
  assign w_count_next = r_p + {{(ADDR_WIDTH-1){1'b0}}, w_accept};

  assign o_mem_ren   = w_rd;
  assign o_mem_raddr = w_rd ? r_p : '0;

  sat_add16 u_sat_add (
    .i_a   (i_mem_rdata),
    .i_b   (r_s1_psum),
    .o_sum (w_add)
  );

  // Channel 0 has nothing in the buffer yet, so its psum passes through.
  assign w_sum = r_s1_rd ? w_add : r_s1_psum;

  // Two-stage datapath: capture the accepted psum, then write back or output.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_rd    <= 1'b0;
      r_s1_final <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_psum  <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_rd    <= w_rd;
      r_s1_final <= w_final;
      r_s1_addr  <= r_p;
      r_s1_psum  <= i_psum_data;
      r_valid    <= r_s1_valid && r_s1_final;
      r_data     <= (r_s1_valid && r_s1_final) ? relu_clip(w_sum, r_relu) : '0;
      r_wen      <= r_s1_valid && !r_s1_final;
      if (r_s1_valid && !r_s1_final) begin
        r_waddr <= r_s1_addr;
        r_wdata <= w_sum;
      end
    end
  end

  // Job control FSM: pixel/channel sequencing, drain, done pulse, sticky error.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
      r_w     <= '0;
      r_h     <= '0;
      r_ci    <= '0;
      r_relu  <= 1'b0;
      r_p     <= '0;
      r_ch    <= '0;
      r_drain <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_w     <= i_max_width;
            r_h     <= i_max_height;
            r_ci    <= i_max_ci;
            r_relu  <= i_relu_en;
            r_p     <= '0;
            r_ch    <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StAccum;
          end
        end
        StAccum: begin
          if (w_accept) r_p <= w_count_next;
          if (w_overflow) r_err <= 1'b1;
          if (i_psum_done) begin
            if (w_count_next != w_total) r_err <= 1'b1;
            r_drain <= 1'b0;
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (i_psum_valid) r_err <= 1'b1;
          if (!r_drain) begin
            r_drain <= 1'b1;
          end else if (r_ch != r_ci) begin
            r_ch    <= r_ch + 10'd1;
            r_p     <= '0;
            r_state <= StAccum;
          end else begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mem_wen   = r_wen;
  assign o_mem_waddr = r_waddr;
  assign o_mem_wdata = r_wdata;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a 1-cycle-latency buffer model.
module tb_psum_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [8:0]         max_w;
  logic [8:0]         max_h;
  logic [9:0]         max_ci;
  logic               relu_en;
  logic signed [15:0] psum_data;
  logic               psum_valid;
  logic               psum_done;
  logic               mem_ren;
  logic [17:0]        mem_raddr;
  logic [15:0]        mem_rdata;
  logic               mem_wen;
  logic [17:0]        mem_waddr;
  logic [15:0]        mem_wdata;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_done;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  psum_accumulator #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (18)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (start),
    .i_max_width  (max_w),
    .i_max_height (max_h),
    .i_max_ci     (max_ci),
    .i_relu_en    (relu_en),
    .i_psum_data  (psum_data),
    .i_psum_valid (psum_valid),
    .i_psum_done  (psum_done),
    .o_mem_ren    (mem_ren),
    .o_mem_raddr  (mem_raddr),
    .i_mem_rdata  (mem_rdata),
    .o_mem_wen    (mem_wen),
    .o_mem_waddr  (mem_waddr),
    .o_mem_wdata  (mem_wdata),
    .o_data       (out_data),
    .o_valid      (out_valid),
    .o_done       (out_done),
    .o_busy       (busy),
    .o_err        (err)
  );

  // Psum buffer model
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_waddr[7:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= mem[mem_raddr[7:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor
  int out_q[$];
  int out_cyc_q[$];
  int in_cyc_q[$];
  int wr_q[$];
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      out_q.push_back(int'(out_data));
      out_cyc_q.push_back(cyc);
    end
    if (mem_wen) wr_q.push_back(int'($signed(mem_wdata)));
    if (mem_ren) rd_cnt <= rd_cnt + 1;
    if (out_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int rd_base = 0;
  int done_base = 0;
  logic signed [15:0] stim [0:15];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int out_at(input int idx);
    return (idx < out_q.size()) ? out_q[idx] : -99999;
  endfunction

  function automatic int wr_at(input int idx);
    return (idx < wr_q.size()) ? wr_q[idx] : -99999;
  endfunction

  task automatic start_job(input int w, input int h, input int ci, input logic relu);
    out_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
    wr_q.delete();
    rd_base   = rd_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    start   = 1'b1;
    max_w   = 9'(w);
    max_h   = 9'(h);
    max_ci  = 10'(ci);
    relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive n psums from stim[]; with_done raises done with the last one and
  // then idles through the two drain cycles.
  task automatic drive_ch(input int n, input logic with_done);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psum_valid = 1'b1;
      psum_data  = stim[i];
      psum_done  = with_done && (i == n - 1);
      in_cyc_q.push_back(cyc);
    end
    if (with_done) begin
      @(posedge clk); #1;
      psum_valid = 1'b0;
      psum_done  = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 100) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    @(posedge clk); #1;
    check_eq({tag, "_done_once"}, done_cnt - done_base, 1);
  endtask

  initial begin
    int lat_bad;
    int last;
    int wr_snap;
    rst_n      = 1'b0;
    start      = 1'b0;
    max_w      = '0;
    max_h      = '0;
    max_ci     = '0;
    relu_en    = 1'b0;
    psum_data  = '0;
    psum_valid = 1'b0;
    psum_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_done", int'(out_done), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_wen", int'(mem_wen), 0);
    check_eq("rst_ren", int'(mem_ren), 0);
    check_eq("rst_data", int'(out_data), 0);
    rst_n = 1'b1;

    // Single channel pass-through, 2-cycle latency
    for (int i = 0; i < 16; i++) stim[i] = 16'(i + 1);
    start_job(4, 4, 0, 1'b0);
    check_eq("t1_busy", int'(busy), 1);
    drive_ch(16, 1'b1);
    wait_done("t1");
    check_eq("t1_count", out_q.size(), 16);
    for (int i = 0; i < 16; i++) check_eq($sformatf("t1_data%0d", i), out_at(i), i + 1);
    lat_bad = 0;
    for (int i = 0; i < out_cyc_q.size() && i < in_cyc_q.size(); i++)
      if (out_cyc_q[i] - in_cyc_q[i] != 2) lat_bad++;
    check_eq("t1_latency", lat_bad, 0);
    last = (out_cyc_q.size() > 0) ? out_cyc_q[out_cyc_q.size() - 1] : -100;
    check_eq("t1_done_cyc", done_cyc, last + 1);
    check_eq("t1_writes", wr_q.size(), 0);
    check_eq("t1_err", int'(err), 0);
    check_eq("t1_idle", int'(busy), 0);

    // Three channels of 100
    for (int i = 0; i < 16; i++) stim[i] = 16'sd100;
    start_job(4, 4, 2, 1'b0);
    for (int c = 0; c < 3; c++) drive_ch(16, 1'b1);
    wait_done("t2");
    check_eq("t2_writes", wr_q.size(), 32);
    check_eq("t2_reads", rd_cnt - rd_base, 32);
    check_eq("t2_wr_first", wr_at(0), 100);
    check_eq("t2_wr_mid", wr_at(15), 100);
    check_eq("t2_wr_ch1", wr_at(16), 200);
    check_eq("t2_wr_last", wr_at(31), 200);
    check_eq("t2_count", out_q.size(), 16);
    for (int i = 0; i < 16; i++) check_eq($sformatf("t2_data%0d", i), out_at(i), 300);

    // Saturation in both directions
    start_job(2, 1, 1, 1'b0);
    stim[0] = 16'sd30000;
    stim[1] = -16'sd30000;
    drive_ch(2, 1'b1);
    stim[0] = 16'sd10000;
    stim[1] = -16'sd10000;
    drive_ch(2, 1'b1);
    wait_done("t3");
    check_eq("t3_sat_pos", out_at(0), 32767);
    check_eq("t3_sat_neg", out_at(1), -32768);

    // ReLU on final sums -5 and 7
    start_job(2, 1, 1, 1'b1);
    stim[0] = -16'sd10;
    stim[1] = 16'sd3;
    drive_ch(2, 1'b1);
    stim[0] = 16'sd5;
    stim[1] = 16'sd4;
    drive_ch(2, 1'b1);
    wait_done("t4");
    check_eq("t4_relu_neg", out_at(0), 0);
    check_eq("t4_relu_pos", out_at(1), 7);

    // Short channel: done after 15 of 16
    for (int i = 0; i < 16; i++) stim[i] = 16'(i + 1);
    start_job(4, 4, 0, 1'b0);
    drive_ch(15, 1'b1);
    wait_done("t5");
    check_eq("t5_err", int'(err), 1);
    check_eq("t5_count", out_q.size(), 15);
    start_job(1, 1, 0, 1'b0);
    check_eq("t5_err_clr", int'(err), 0);
    stim[0] = 16'sd42;
    drive_ch(1, 1'b1);
    wait_done("t5b");
    check_eq("t5b_data", out_at(0), 42);
    check_eq("t5b_err", int'(err), 0);

    // Pixel overflow: extra psum is neither written nor counted
    start_job(1, 1, 1, 1'b0);
    stim[0] = 16'sd5;
    stim[1] = 16'sd6;
    drive_ch(2, 1'b1);
    stim[0] = 16'sd7;
    drive_ch(1, 1'b1);
    wait_done("t6");
    check_eq("t6_writes", wr_q.size(), 1);
    check_eq("t6_data", out_at(0), 12);
    check_eq("t6_err", int'(err), 1);

    // Reset in the middle of channel 1 with writes in flight
    for (int i = 0; i < 16; i++) stim[i] = 16'sd1;
    start_job(4, 4, 2, 1'b0);
    drive_ch(16, 1'b1);
    drive_ch(5, 1'b0);
    #2;
    rst_n = 1'b0;
    wr_snap = wr_q.size();
    #1;
    check_eq("t7_busy", int'(busy), 0);
    check_eq("t7_valid", int'(out_valid), 0);
    check_eq("t7_wen", int'(mem_wen), 0);
    check_eq("t7_ren", int'(mem_ren), 0);
    check_eq("t7_err", int'(err), 0);
    check_eq("t7_waddr", int'(mem_waddr), 0);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t7_no_write", wr_q.size(), wr_snap);
    check_eq("t7_idle", int'(busy), 0);
    check_eq("t7_no_done", done_cnt - done_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
